// File: rtl/ballot_input_conditioner.sv
// Candidate-button conditioner: 2-flop sync + debounce, one-ballot-per-authorisation FSM, ballot tally.
// Optional ARMED idle timeout is compiled in when VOTER_TIMEOUT_EN is defined.
module ballot_input_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned DB_CNT_W        = 5,
   parameter int unsigned TIMEOUT_CYCLES  = 1000,
   parameter int unsigned TO_CNT_W        = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  i_btn,
   input  logic        i_voter_arm,
   input  logic        i_voting_over,
   output logic [2:0]  o_cand_pulse,
   output logic        o_ready,
   output logic        o_reject,
   output logic        o_timeout,
   output logic [15:0] o_ballots_cast
);
   localparam int unsigned N_BTN   = 3;
   localparam int unsigned TALLY_W = 16;

   if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) >= (64'd1 << DB_CNT_W)) begin : g_bad_db_cfg
      $error("DEBOUNCE_CYCLES must be >= 2 and fit in DB_CNT_W");
   end
   if (TIMEOUT_CYCLES < 1 || 64'(TIMEOUT_CYCLES) >= (64'd1 << TO_CNT_W)) begin : g_bad_to_cfg
      $error("TIMEOUT_CYCLES must be >= 1 and fit in TO_CNT_W");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_ARM_WAIT, S_ARMED, S_PRESSED, S_REJ_WAIT, S_CLOSED
   } state_t;

   logic [N_BTN-1:0]    r_sync1;
   logic [N_BTN-1:0]    r_sync2;
   logic [N_BTN-1:0]    r_deb;
   logic [DB_CNT_W-1:0] r_db_cnt [N_BTN];

   state_t              r_state;
   logic [N_BTN-1:0]    r_cand;
   logic [N_BTN-1:0]    r_pulse;
   logic                r_ready;
   logic                r_reject;
   logic                r_timeout;
   logic [TALLY_W-1:0]  r_ballots;

   logic w_deb_zero;
   logic w_deb_one;
   logic w_deb_multi;
   logic w_deb_extra;
   logic w_to_hit;

   // Synchroniser and per-bit debounce: deb follows sync after DEBOUNCE_CYCLES consecutive mismatches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_deb   <= '0;
         for (int i = 0; i < N_BTN; i++) r_db_cnt[i] <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         for (int i = 0; i < N_BTN; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_db_cnt[i] <= '0;
            end else if (r_db_cnt[i] == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               r_deb[i]    <= r_sync2[i];
               r_db_cnt[i] <= '0;
            end else begin
               r_db_cnt[i] <= r_db_cnt[i] + DB_CNT_W'(1);
            end
         end
      end
   end

   assign w_deb_zero  = (r_deb == '0);
   assign w_deb_one   = $onehot(r_deb);
   assign w_deb_multi = !w_deb_zero && !w_deb_one;
   assign w_deb_extra = |(r_deb & ~r_cand);

`ifdef VOTER_TIMEOUT_EN
   logic [TO_CNT_W-1:0] r_to_cnt;

   assign w_to_hit = (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));

   // Idle time in ARMED; held at zero in every other state so entry always starts fresh
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_to_cnt <= '0;
      end else if (r_state == S_ARMED && !w_to_hit) begin
         r_to_cnt <= r_to_cnt + TO_CNT_W'(1);
      end else begin
         r_to_cnt <= '0;
      end
   end
`else
   assign w_to_hit = 1'b0;
`endif

   // Ballot FSM; outputs are registered alongside the state transition that produces them
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_cand    <= '0;
         r_pulse   <= '0;
         r_ready   <= 1'b0;
         r_reject  <= 1'b0;
         r_timeout <= 1'b0;
         r_ballots <= '0;
      end else begin
         r_pulse   <= '0;
         r_reject  <= 1'b0;
         r_timeout <= 1'b0;
         if (i_voting_over) begin
            r_state <= S_CLOSED;
            r_ready <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (i_voter_arm) begin
                     if (w_deb_zero) begin
                        r_state <= S_ARMED;
                        r_ready <= 1'b1;
                     end else begin
                        r_state <= S_ARM_WAIT;
                     end
                  end
               end
               S_ARM_WAIT: begin
                  if (w_deb_zero) begin
                     r_state <= S_ARMED;
                     r_ready <= 1'b1;
                  end
               end
               S_ARMED: begin
                  if (w_deb_one) begin
                     r_cand  <= r_deb;
                     r_state <= S_PRESSED;
                     r_ready <= 1'b0;
                  end else if (w_deb_multi) begin
                     r_state  <= S_REJ_WAIT;
                     r_reject <= 1'b1;
                     r_ready  <= 1'b0;
                  end else if (w_to_hit) begin
                     r_state   <= S_IDLE;
                     r_timeout <= 1'b1;
                     r_ready   <= 1'b0;
                  end
               end
               S_PRESSED: begin
                  if (w_deb_extra) begin
                     r_state  <= S_REJ_WAIT;
                     r_reject <= 1'b1;
                  end else if (w_deb_zero) begin
                     r_state <= S_IDLE;
                     r_pulse <= r_cand;
                     if (r_ballots != '1) r_ballots <= r_ballots + TALLY_W'(1);
                  end
               end
               S_REJ_WAIT: begin
                  if (w_deb_zero) begin
                     r_state <= S_ARMED;
                     r_ready <= 1'b1;
                  end
               end
               S_CLOSED: begin
                  r_state <= S_IDLE;
               end
               default: begin
                  r_state <= S_IDLE;
                  r_ready <= 1'b0;
               end
            endcase
         end
      end
   end

   assign o_cand_pulse   = r_pulse;
   assign o_ready        = r_ready;
   assign o_reject       = r_reject;
   assign o_timeout      = r_timeout;
   assign o_ballots_cast = r_ballots;

endmodule

// File: tb/tb_ballot_input_conditioner.sv
// Bench for ballot_input_conditioner: directed plan steps then random button/arm traffic,
// every cycle compared against a behavioural model of the ballot rules.
module tb_ballot_input_conditioner;
   localparam int unsigned DEB = 4;
   localparam int unsigned TO  = 50;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  i_btn;
   logic        i_voter_arm;
   logic        i_voting_over;
   logic [2:0]  o_cand_pulse;
   logic        o_ready;
   logic        o_reject;
   logic        o_timeout;
   logic [15:0] o_ballots_cast;

   int total = 0;
   int bad   = 0;
   int n_pulse, n_reject, n_timeout;
   logic [2:0] last_pulse;

   // Model: voter phases named after the ballot rules
   localparam int M_IDLE = 0, M_WAIT_CLEAR = 1, M_ARMED = 2, M_HOLD = 3, M_REJ = 4, M_CLOSED = 5;
   int         m_mode;
   int         m_armed_cycles;
   logic [2:0] m_cand;
   logic [2:0] m_deb;
   logic [2:0] m_raw_hist [$];
   logic [2:0] m_pulse;
   logic       m_ready, m_reject, m_timeout;
   int         m_count;

   ballot_input_conditioner #(
      .DEBOUNCE_CYCLES(DEB),
      .DB_CNT_W       (5),
      .TIMEOUT_CYCLES (TO),
      .TO_CNT_W       (10)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .i_btn         (i_btn),
      .i_voter_arm   (i_voter_arm),
      .i_voting_over (i_voting_over),
      .o_cand_pulse  (o_cand_pulse),
      .o_ready       (o_ready),
      .o_reject      (o_reject),
      .o_timeout     (o_timeout),
      .o_ballots_cast(o_ballots_cast)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE;
      m_armed_cycles = 0;
      m_cand = '0;
      m_deb = '0;
      m_raw_hist.delete();
      for (int k = 0; k <= int'(DEB); k++) m_raw_hist.push_back(3'b000);
      m_pulse = '0;
      m_ready = 1'b0;
      m_reject = 1'b0;
      m_timeout = 1'b0;
      m_count = 0;
   endtask

   // One clock edge of the ballot rules; raw history index k holds the button value from k+1 edges ago
   task automatic model_step();
      logic [2:0] new_deb;
      int differ;
      if (!rst) begin
         model_reset();
         return;
      end
      m_pulse = '0;
      m_reject = 1'b0;
      m_timeout = 1'b0;
      if (i_voting_over) begin
         m_mode = M_CLOSED;
      end else begin
         case (m_mode)
            M_IDLE: if (i_voter_arm) begin
               m_mode = (m_deb == 3'b000) ? M_ARMED : M_WAIT_CLEAR;
               m_armed_cycles = 0;
            end
            M_WAIT_CLEAR: if (m_deb == 3'b000) begin
               m_mode = M_ARMED;
               m_armed_cycles = 0;
            end
            M_ARMED: begin
               if ($countones(m_deb) == 1) begin
                  m_cand = m_deb;
                  m_mode = M_HOLD;
               end else if ($countones(m_deb) > 1) begin
                  m_mode = M_REJ;
                  m_reject = 1'b1;
               end else begin
                  m_armed_cycles++;
`ifdef VOTER_TIMEOUT_EN
                  if (m_armed_cycles >= int'(TO)) begin
                     m_mode = M_IDLE;
                     m_timeout = 1'b1;
                  end
`endif
               end
            end
            M_HOLD: begin
               if ((m_deb & ~m_cand) != 3'b000) begin
                  m_mode = M_REJ;
                  m_reject = 1'b1;
               end else if (m_deb == 3'b000) begin
                  m_mode = M_IDLE;
                  m_pulse = m_cand;
                  if (m_count < 65535) m_count++;
               end
            end
            M_REJ: if (m_deb == 3'b000) begin
               m_mode = M_ARMED;
               m_armed_cycles = 0;
            end
            default: m_mode = M_IDLE;
         endcase
      end
      m_ready = (m_mode == M_ARMED);
      // A button level is accepted once the last DEB synchronised samples all disagree with it
      new_deb = m_deb;
      for (int b = 0; b < 3; b++) begin
         differ = 0;
         for (int k = 1; k <= int'(DEB); k++) if (m_raw_hist[k][b] != m_deb[b]) differ++;
         if (differ == int'(DEB)) new_deb[b] = ~m_deb[b];
      end
      m_deb = new_deb;
      m_raw_hist.push_front(i_btn);
      void'(m_raw_hist.pop_back());
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      if (o_cand_pulse != 3'b000) begin
         n_pulse++;
         last_pulse = o_cand_pulse;
      end
      if (o_reject) n_reject++;
      if (o_timeout) n_timeout++;
      check("cand_pulse", 32'(o_cand_pulse), 32'(m_pulse));
      check("ready", 32'(o_ready), 32'(m_ready));
      check("reject", 32'(o_reject), 32'(m_reject));
      check("timeout", 32'(o_timeout), 32'(m_timeout));
      check("ballots", 32'(o_ballots_cast), 32'(m_count));
   endtask

   task automatic hold(input logic [2:0] b, input int n);
      i_btn = b;
      repeat (n) tick();
   endtask

   task automatic arm();
      i_voter_arm = 1'b1;
      tick();
      i_voter_arm = 1'b0;
   endtask

   task automatic clear_counts();
      n_pulse = 0;
      n_reject = 0;
      n_timeout = 0;
      last_pulse = 3'b000;
   endtask

   initial begin
      rst = 1'b0;
      i_btn = 3'b000;
      i_voter_arm = 1'b0;
      i_voting_over = 1'b0;
      model_reset();
      clear_counts();
      repeat (3) tick();
      check("rst_pulse", 32'(o_cand_pulse), 32'd0);
      check("rst_ballots", 32'(o_ballots_cast), 32'd0);
      rst = 1'b1;
      tick();

      // 1: single accepted ballot for candidate 2
      clear_counts();
      arm();
      check("s1_ready_armed", 32'(o_ready), 32'd1);
      hold(3'b010, 20);
      hold(3'b000, 10);
      check("s1_npulse", 32'(n_pulse), 32'd1);
      check("s1_value", 32'(last_pulse), 32'(3'b010));
      check("s1_count", 32'(o_ballots_cast), 32'd1);
      check("s1_ready_after", 32'(o_ready), 32'd0);

      // 2: unauthorised press ignored; arm with button held waits for release
      clear_counts();
      hold(3'b001, 10);
      hold(3'b000, 10);
      check("s2_unarmed_npulse", 32'(n_pulse), 32'd0);
      check("s2_unarmed_count", 32'(o_ballots_cast), 32'd1);
      hold(3'b100, 10);
      arm();
      repeat (2) tick();
      check("s2_wait_ready", 32'(o_ready), 32'd0);
      hold(3'b000, 10);
      check("s2_armed_ready", 32'(o_ready), 32'd1);
      hold(3'b100, 10);
      hold(3'b000, 10);
      check("s2_npulse", 32'(n_pulse), 32'd1);
      check("s2_value", 32'(last_pulse), 32'(3'b100));
      check("s2_count", 32'(o_ballots_cast), 32'd2);

      // 3: two-button press rejected, retry keeps the authorisation
      clear_counts();
      arm();
      hold(3'b101, 10);
      check("s3_nreject", 32'(n_reject), 32'd1);
      check("s3_nopulse", 32'(n_pulse), 32'd0);
      hold(3'b000, 10);
      check("s3_rearmed", 32'(o_ready), 32'd1);
      hold(3'b001, 10);
      hold(3'b000, 10);
      check("s3_npulse", 32'(n_pulse), 32'd1);
      check("s3_value", 32'(last_pulse), 32'(3'b001));
      check("s3_count", 32'(o_ballots_cast), 32'd3);

      // 4: short glitch filtered, bouncing press yields one ballot
      clear_counts();
      arm();
      hold(3'b010, 3);
      hold(3'b000, 10);
      check("s4_glitch_ready", 32'(o_ready), 32'd1);
      check("s4_glitch_npulse", 32'(n_pulse), 32'd0);
      hold(3'b010, 1);
      hold(3'b000, 2);
      hold(3'b010, 2);
      hold(3'b000, 1);
      hold(3'b010, 10);
      hold(3'b000, 10);
      check("s4_npulse", 32'(n_pulse), 32'd1);
      check("s4_value", 32'(last_pulse), 32'(3'b010));
      check("s4_count", 32'(o_ballots_cast), 32'd4);

      // 5: voting closes mid-press, then asynchronous reset mid-press
      clear_counts();
      arm();
      hold(3'b001, 10);
      i_voting_over = 1'b1;
      hold(3'b001, 3);
      hold(3'b000, 10);
      check("s5_closed_npulse", 32'(n_pulse), 32'd0);
      check("s5_closed_count", 32'(o_ballots_cast), 32'd4);
      check("s5_closed_ready", 32'(o_ready), 32'd0);
      i_voting_over = 1'b0;
      tick();
      arm();
      hold(3'b001, 10);
      #2;
      rst = 1'b0;
      i_btn = 3'b000;
      model_reset();
      #1;
      check("s5_arst_pulse", 32'(o_cand_pulse), 32'd0);
      check("s5_arst_ready", 32'(o_ready), 32'd0);
      check("s5_arst_reject", 32'(o_reject), 32'd0);
      check("s5_arst_timeout", 32'(o_timeout), 32'd0);
      check("s5_arst_count", 32'(o_ballots_cast), 32'd0);
      repeat (2) tick();
      rst = 1'b1;
      tick();

      // 6: idle voter
      clear_counts();
      arm();
      repeat (60) tick();
`ifdef VOTER_TIMEOUT_EN
      check("s6_ntimeout", 32'(n_timeout), 32'd1);
      check("s6_ready", 32'(o_ready), 32'd0);
      hold(3'b010, 10);
      hold(3'b000, 10);
      check("s6_late_npulse", 32'(n_pulse), 32'd0);
`else
      repeat (140) tick();
      check("s6_ready", 32'(o_ready), 32'd1);
      check("s6_ntimeout", 32'(n_timeout), 32'd0);
`endif

      // Random traffic: button patterns with random hold times, arms and closures
      for (int s = 0; s < 300; s++) begin
         logic [2:0] pat;
         int len;
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 3) pat = 3'b000;
         else if (r < 8) pat = 3'b001 << $urandom_range(0, 2);
         else pat = 3'($urandom_range(0, 7));
         len = int'($urandom_range(1, 12));
         i_voting_over = ($urandom_range(0, 29) == 0);
         i_voter_arm = ($urandom_range(0, 3) == 0);
         i_btn = pat;
         tick();
         i_voter_arm = 1'b0;
         repeat (len - 1) tick();
      end
      i_voting_over = 1'b0;
      hold(3'b000, 10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
